// File: rtl/onchip_mem_arbiter_if.sv
// Two-requester burst read bus plus the on-chip memory port.
// slave: the arbiter side; master: requesters and memory model.
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 256
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic [ADDR_W:0]   m0_len;
  logic              m0_gnt;
  logic              m0_rdata_valid;
  logic              m0_done;

  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic [ADDR_W:0]   m1_len;
  logic              m1_gnt;
  logic              m1_rdata_valid;
  logic              m1_done;

  logic [DATA_W-1:0] rdata;

  logic              mem_chip_select;
  logic              mem_clk_ena;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  m0_req, m0_addr, m0_len,
    input  m1_req, m1_addr, m1_len,
    input  mem_read_data,
    output m0_gnt, m0_rdata_valid, m0_done,
    output m1_gnt, m1_rdata_valid, m1_done,
    output rdata,
    output mem_chip_select, mem_clk_ena,
    output mem_read, mem_addr
  );

  modport master (
    output m0_req, m0_addr, m0_len,
    output m1_req, m1_addr, m1_len,
    output mem_read_data,
    input  m0_gnt, m0_rdata_valid, m0_done,
    input  m1_gnt, m1_rdata_valid, m1_done,
    input  rdata,
    input  mem_chip_select, mem_clk_ena,
    input  mem_read, mem_addr
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Round-robin burst-read arbiter for two requesters sharing one
// on-chip memory; read owner travels with each read to tag rdata.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 256,
  parameter int RD_LAT = 2
) (
  input logic clk,
  input logic rst_n,
  onchip_mem_arbiter_if.slave bus
);
  localparam int LW = ADDR_W + 1;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LW-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t            r_state;
  logic              r_own;
  logic              r_last1;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_done0;
  logic              r_done1;
  logic              r_rd;
  logic              r_cs;
  logic              r_ena;
  logic [ADDR_W-1:0] r_addr;
  logic [LW-1:0]     r_left;
  logic [CW-1:0]     r_drain;
  logic [RD_LAT-1:0] r_pv;
  logic [RD_LAT-1:0] r_pid;
  logic              r_rv0;
  logic              r_rv1;
  logic [DATA_W-1:0] r_rdata;

  logic              w_any;
  logic              w_pick1;
  logic [LW-1:0]     w_raw;
  logic [LW-1:0]     w_len;
  logic [ADDR_W-1:0] w_start;

  // r_last1 set means m1 was granted last, so a tie goes to m0
  always_comb begin
    w_any   = bus.m0_req | bus.m1_req;
    w_pick1 = bus.m1_req & (~bus.m0_req | ~r_last1);
    w_raw   = w_pick1 ? bus.m1_len : bus.m0_len;
    w_start = w_pick1 ? bus.m1_addr : bus.m0_addr;
    w_len   = (w_raw > MAX_LEN) ? MAX_LEN : w_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_own   <= 1'b0;
      r_last1 <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_rd    <= 1'b0;
      r_cs    <= 1'b0;
      r_ena   <= 1'b0;
      r_addr  <= '0;
      r_left  <= '0;
      r_drain <= '0;
    end else begin
      r_ena   <= 1'b1;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_own   <= w_pick1;
            r_last1 <= w_pick1;
            r_gnt0  <= ~w_pick1;
            r_gnt1  <= w_pick1;
            r_state <= ISSUE;
            if (w_len != '0) begin
              r_rd   <= 1'b1;
              r_cs   <= 1'b1;
              r_addr <= w_start;
              r_left <= w_len - LW'(1);
            end
          end
        end
        ISSUE: begin
          // no read outstanding here means a zero-length burst
          if (!r_rd) begin
            r_state <= DONE;
            r_done0 <= ~r_own;
            r_done1 <= r_own;
          end else if (r_left == '0) begin
            r_rd    <= 1'b0;
            r_cs    <= 1'b0;
            r_addr  <= '0;
            r_drain <= CW'(RD_LAT - 1);
            r_state <= DRAIN;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
            r_left <= r_left - LW'(1);
          end
        end
        DRAIN: begin
          if (r_drain == '0) begin
            r_state <= DONE;
            r_done0 <= ~r_own;
            r_done1 <= r_own;
          end else begin
            r_drain <= r_drain - CW'(1);
          end
        end
        DONE: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // owner tags ride alongside the memory latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv    <= '0;
      r_pid   <= '0;
      r_rv0   <= 1'b0;
      r_rv1   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_pv    <= (r_pv << 1) | RD_LAT'(r_rd);
      r_pid   <= (r_pid << 1) | RD_LAT'(r_own);
      r_rv0   <= r_pv[RD_LAT-1] & ~r_pid[RD_LAT-1];
      r_rv1   <= r_pv[RD_LAT-1] & r_pid[RD_LAT-1];
      r_rdata <= bus.mem_read_data;
    end
  end

  assign bus.m0_gnt          = r_gnt0;
  assign bus.m1_gnt          = r_gnt1;
  assign bus.m0_done         = r_done0;
  assign bus.m1_done         = r_done1;
  assign bus.m0_rdata_valid  = r_rv0;
  assign bus.m1_rdata_valid  = r_rv1;
  assign bus.rdata           = r_rdata;
  assign bus.mem_read        = r_rd;
  assign bus.mem_chip_select = r_cs;
  assign bus.mem_clk_ena     = r_ena;
  assign bus.mem_addr        = r_addr;
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: vector table of single bursts,
// scoreboard on reads/rdata, and sequences for arbitration and reset.
module tb_onchip_mem_arbiter;
  localparam int AW = 13;
  localparam int DW = 256;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  onchip_mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .RD_LAT(RL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mdat(input logic [AW-1:0] a);
    return {8{32'hC0DE_0000 ^ 32'(a)}};
  endfunction

  // memory model: data RL cycles after the read issue
  logic [DW-1:0] p1 = '0;
  logic [DW-1:0] p2 = '0;
  always @(posedge clk) begin
    p1 <= bus.mem_read ? mdat(bus.mem_addr) : '0;
    p2 <= p1;
  end
  assign bus.mem_read_data = p2;

  task automatic check(input string nm, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    int              who;
    logic [DW-1:0]   d;
  } exp_t;

  typedef struct {
    int              who;
    logic [AW-1:0]   addr;
    logic [AW:0]     len;
    int              lat;
    int              n;
  } vec_t;

  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            iss_q[$];
  exp_t          e;
  int nv0 = 0, nv1 = 0, dn0 = 0, dn1 = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_read) begin
        if (addr_q.size() == 0) check("unexp_read", 1, 0);
        else check("mem_addr", bus.mem_addr, addr_q.pop_front());
        check("mem_cs", bus.mem_chip_select, 1);
        iss_q.push_back(cyc);
      end
      if (!bus.m0_gnt && !bus.m1_gnt)
        check("idle_bus", {bus.mem_read, bus.mem_chip_select,
                           bus.mem_addr}, 0);
      check("gnt_excl", bus.m0_gnt & bus.m1_gnt, 0);
      check("valid_excl", bus.m0_rdata_valid & bus.m1_rdata_valid, 0);
      if (bus.m0_rdata_valid || bus.m1_rdata_valid) begin
        if (bus.m0_rdata_valid) nv0++;
        else nv1++;
        if (exp_q.size() == 0) begin
          check("unexp_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("owner", bus.m1_rdata_valid, e.who);
          check("rdata", bus.rdata, e.d);
        end
        if (iss_q.size() == 0) check("lat_noissue", 1, 0);
        else check("rd_lat", cyc - iss_q.pop_front(), RL + 1);
      end
      if (bus.m0_done) dn0++;
      if (bus.m1_done) dn1++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_burst(input int who, input logic [AW-1:0] a,
                            input int n);
    for (int i = 0; i < n; i++) begin
      addr_q.push_back(a + AW'(i));
      exp_q.push_back('{who, mdat(a + AW'(i))});
    end
  endtask

  task automatic set_req(input int who, input bit r,
                         input logic [AW-1:0] a, input logic [AW:0] l);
    if (who == 0) begin
      bus.m0_req = r; bus.m0_addr = a; bus.m0_len = l;
    end else begin
      bus.m1_req = r; bus.m1_addr = a; bus.m1_len = l;
    end
  endtask

  task automatic wait_done(input int who, input int budget,
                           output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((who == 0) ? bus.m0_done : bus.m1_done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("done_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int a0, at, n0, d0;
    n0 = v.who ? nv1 : nv0;
    d0 = v.who ? dn1 : dn0;
    push_burst(v.who, v.addr, v.n);
    set_req(v.who, 1'b1, v.addr, v.len);
    a0 = cyc;
    @(negedge clk);
    check("gnt", v.who ? bus.m1_gnt : bus.m0_gnt, 1);
    wait_done(v.who, v.lat + 20, at);
    set_req(v.who, 1'b0, '0, '0);
    check("done_lat", at - a0, v.lat);
    tick(4);
    check("valid_cnt", (v.who ? nv1 : nv0) - n0, v.n);
    check("done_cnt", (v.who ? dn1 : dn0) - d0, 1);
    check("q_empty", exp_q.size(), 0);
  endtask

  vec_t vecs[7];

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int a0, at, d0, d1, v0, v1;
    vecs[0] = '{0, 13'h0010, 14'd4,    7,    4};
    vecs[1] = '{1, 13'h1FFE, 14'd4,    7,    4};
    vecs[2] = '{0, 13'h0000, 14'd0,    2,    0};
    vecs[3] = '{1, 13'h0123, 14'd1,    4,    1};
    vecs[4] = '{1, 13'h0055, 14'd0,    2,    0};
    vecs[5] = '{0, 13'h1FFF, 14'd2,    5,    2};
    vecs[6] = '{0, 13'h00AB, 14'h3FFF, 8195, 8192};

    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    #12;
    check("rst_ctl", {bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done,
                      bus.m0_rdata_valid, bus.m1_rdata_valid,
                      bus.mem_read, bus.mem_chip_select,
                      bus.mem_clk_ena, bus.mem_addr}, 0);
    check("rst_rdata", bus.rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("clk_ena", bus.mem_clk_ena, 1);

    // simultaneous requests after reset, then round-robin
    d0 = dn0; d1 = dn1;
    push_burst(0, 13'h040, 2);
    push_burst(1, 13'h080, 2);
    push_burst(0, 13'h0C0, 2);
    set_req(0, 1'b1, 13'h040, 14'd2);
    set_req(1, 1'b1, 13'h080, 14'd2);
    a0 = cyc;
    @(negedge clk);
    check("tie_m0_gnt", bus.m0_gnt, 1);
    check("tie_m1_wait", bus.m1_gnt, 0);
    bus.m0_addr = 13'h3FF;
    bus.m0_len = 14'd9;
    wait_done(0, 30, at);
    check("tie_lat", at - a0, 5);
    bus.m0_addr = 13'h0C0;
    bus.m0_len = 14'd2;
    tick(2);
    check("rr_m1_gnt", bus.m1_gnt, 1);
    check("rr_m0_wait", bus.m0_gnt, 0);
    wait_done(1, 30, at);
    set_req(1, 1'b0, '0, '0);
    tick(2);
    check("rr_m0_gnt", bus.m0_gnt, 1);
    wait_done(0, 30, at);
    set_req(0, 1'b0, '0, '0);
    tick(4);
    check("rr_done0", dn0 - d0, 2);
    check("rr_done1", dn1 - d1, 1);
    check("rr_q_empty", exp_q.size(), 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // m1 arrives mid-burst, served right after m0 finishes
    push_burst(0, 13'h300, 3);
    push_burst(1, 13'h310, 2);
    set_req(0, 1'b1, 13'h300, 14'd3);
    @(negedge clk);
    set_req(1, 1'b1, 13'h310, 14'd2);
    wait_done(0, 30, at);
    set_req(0, 1'b0, '0, '0);
    @(negedge clk);
    check("m1_not_yet", bus.m1_gnt, 0);
    @(negedge clk);
    check("m1_after_done", bus.m1_gnt, 1);
    wait_done(1, 30, at);
    set_req(1, 1'b0, '0, '0);
    tick(4);
    check("seq_q_empty", exp_q.size(), 0);

    // request withdrawn before grant is dropped
    d1 = dn1;
    push_burst(0, 13'h400, 3);
    set_req(0, 1'b1, 13'h400, 14'd3);
    @(negedge clk);
    set_req(1, 1'b1, 13'h500, 14'd2);
    @(negedge clk);
    set_req(1, 1'b0, '0, '0);
    wait_done(0, 30, at);
    set_req(0, 1'b0, '0, '0);
    tick(6);
    check("drop_no_done", dn1 - d1, 0);
    check("drop_q_empty", exp_q.size(), 0);

    // reset in the middle of a len=8 burst
    push_burst(0, 13'h200, 8);
    set_req(0, 1'b1, 13'h200, 14'd8);
    tick(3);
    d0 = dn0; v0 = nv0; v1 = nv1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", {bus.m0_gnt, bus.m1_gnt, bus.m0_done,
                          bus.m1_done, bus.m0_rdata_valid,
                          bus.m1_rdata_valid, bus.mem_read,
                          bus.mem_chip_select, bus.mem_clk_ena,
                          bus.mem_addr}, 0);
    check("mid_rst_rdata", bus.rdata, 0);
    exp_q.delete();
    addr_q.delete();
    iss_q.delete();
    set_req(0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ena", bus.mem_clk_ena, 1);
    tick(10);
    check("mid_rst_no_done", dn0 - d0, 0);
    check("mid_rst_no_valid", (nv0 - v0) + (nv1 - v1), 0);
    run_vec(vecs[0]);
    run_vec(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
